asel_fwd_stage: RTL and testbench
=================================

Name: asel_fwd_stage

Overview:
Parametrised successor to the ALU operand-A select. It chooses operand A from the register file, the PC, zero, or PC+4. In register mode it bypasses from NUM_FWD forwarding channels (EX/MEM/WB results). It detects load-use hazards on pending channels and stalls upstream. The result is held in a valid/ready pipeline register at the ID/EX boundary.

Parameters:
XLEN, 32, datapath width in bits
NUM_FWD, 3, forwarding channels; index 0 is the youngest and has highest priority
REG_AW, 5, register address width
CNT_W, 4, width of the saturating stall counter

Ports:
clk_i  in  1  core clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  discard the held entry and block capture this cycle
in_valid_i  in  1  upstream operand request valid
in_ready_o  out  1  stage accepts a request this cycle
asel_i  in  2  mode: 0 REG, 1 PC, 2 ZERO, 3 PC4
rs_addr_i  in  REG_AW  source register address
reg_data_i  in  XLEN  register file read data
pc_i  in  XLEN  instruction address
fwd_valid_i  in  NUM_FWD  channel k carries a register write
fwd_pending_i  in  NUM_FWD  channel k result not yet available (load in flight)
fwd_rd_i  in  NUM_FWD*REG_AW  channel k destination, packed k*REG_AW upward
fwd_data_i  in  NUM_FWD*XLEN  channel k result, packed k*XLEN upward
out_valid_o  out  1  held operand valid
out_ready_i  in  1  downstream consumes the held operand
data_a_o  out  XLEN  registered operand A
hazard_o  out  1  combinational load-use stall indication
stall_cnt_o  out  CNT_W  consecutive hazard cycles, saturating

Behaviour:
- Reset (rst_n_i low, asynchronous): out_valid_o=0, data_a_o=0, stall_cnt_o=0.
- Channel k matches when fwd_valid_i[k]=1 and fwd_rd_i[k]==rs_addr_i. rs_addr_i==0 never matches and always yields reg_data_i, which the register file returns as 0.
- The winner is the lowest-index matching channel. The other matches are ignored, including pending ones.
- hazard_o = in_valid_i & (asel_i==REG) & winner exists & fwd_pending_i[winner].
- Selected value by mode:
  - REG: fwd_data of the winner if one exists, else reg_data_i.
  - PC: pc_i.
  - ZERO: all zeros.
  - PC4: pc_i+4, truncated to XLEN with the carry dropped.
- In non-REG modes, forwarding and hazard are ignored.
- in_ready_o = (~out_valid_o | out_ready_i) & ~hazard_o & ~flush_i.
- Capture happens when in_valid_i & in_ready_o. The next edge sets out_valid_o=1 and data_a_o=selected value. Latency is 1 cycle.
- Drain without capture: when out_valid_o & out_ready_i, the next edge clears out_valid_o.
- Drain and capture in the same cycle: the new value loads and out_valid_o stays 1. This gives full throughput.
- Hold: out_valid_o & ~out_ready_i keeps data_a_o and out_valid_o stable, whatever the inputs do.
- flush_i: the next edge clears out_valid_o and stall_cnt_o. There is no capture that cycle, even with in_valid_i=1. data_a_o may keep its old value. Flush has priority over drain, capture and hazard.
- stall_cnt_o increments on each edge where hazard_o=1 and saturates at 2^CNT_W-1. It clears on any edge where hazard_o=0.
- Hazard while the output is held: in_ready_o=0 and the held entry is unaffected.
- Combinational path from fwd_*, rs_addr_i and asel_i to in_ready_o and hazard_o is permitted. There is no combinational path to data_a_o.

Test Plan:
- Mode select: asel=PC, pc=0x0000_1000 -> data_a=0x1000 one cycle after capture. asel=PC4, pc=0xFFFF_FFFC -> 0x0. asel=ZERO -> 0x0.
- Priority forwarding: rs=5, ch0 rd=5 data=0xAAAA, ch2 rd=5 data=0xBBBB, reg_data=0x1111 -> 0xAAAA. Clear ch0 valid -> 0xBBBB. No matches -> 0x1111.
- x0 guard: rs=0, ch0 rd=0 valid data=0xDEAD, reg_data=0 -> data_a=0, no hazard.
- Load-use: rs=7, ch0 rd=7 pending for 3 cycles -> hazard_o=1 and in_ready_o=0 for 3 cycles, stall_cnt 1,2,3. Pending drops with data 0x42 -> capture 0x42, stall_cnt returns to 0. A 20-cycle stall saturates the counter at 15.
- Backpressure: out_ready=0 with the output held at 0x10 while new requests arrive -> data_a stays 0x10, in_ready=0. Raise out_ready with in_valid=1 -> the new value loads the same edge and out_valid stays 1.
- Flush and reset: flush_i with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, nothing captured. Assert rst_n_i low mid-stall with stall_cnt=5 -> out_valid=0, data_a=0, stall_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/asel_fwd_stage.sv
// ALU operand-A select stage with priority forwarding, load-use stall
// detection and a valid/ready output register at the ID/EX boundary.
module asel_fwd_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [1:0]                asel_i,
  input  logic [REG_AW-1:0]         rs_addr_i,
  input  logic [XLEN-1:0]           reg_data_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic [NUM_FWD-1:0]        fwd_valid_i,
  input  logic [NUM_FWD-1:0]        fwd_pending_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [XLEN-1:0]           data_a_o,
  output logic                      hazard_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  typedef enum logic [1:0] {
    SEL_REG  = 2'd0,
    SEL_PC   = 2'd1,
    SEL_ZERO = 2'd2,
    SEL_PC4  = 2'd3
  } asel_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  asel_e           mode;
  logic            win_found;
  logic            win_pending;
  logic [XLEN-1:0] win_data;
  logic [XLEN-1:0] sel_value;
  logic            capture;

  assign mode = asel_e'(asel_i);

  // Scan channels from oldest to youngest so the lowest-index match wins;
  // x0 is never forwarded because it always reads as zero.
  always_comb begin
    win_found   = 1'b0;
    win_pending = 1'b0;
    win_data    = reg_data_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid_i[k] && (rs_addr_i != '0) &&
          (fwd_rd_i[k*REG_AW +: REG_AW] == rs_addr_i)) begin
        win_found   = 1'b1;
        win_pending = fwd_pending_i[k];
        win_data    = fwd_data_i[k*XLEN +: XLEN];
      end
    end
  end

  // Mode multiplexer; PC+4 wraps silently at the top of the address space.
  always_comb begin
    sel_value = '0;
    unique case (mode)
      SEL_REG:  sel_value = win_data;
      SEL_PC:   sel_value = pc_i;
      SEL_ZERO: sel_value = '0;
      SEL_PC4:  sel_value = pc_i + XLEN'(4);
      default:  sel_value = '0;
    endcase
  end

  assign hazard_o   = in_valid_i & (mode == SEL_REG) & win_found & win_pending;
  assign in_ready_o = (~out_valid_o | out_ready_i) & ~hazard_o & ~flush_i;
  assign capture    = in_valid_i & in_ready_o;

  // Output register: flush discards, capture loads (also while draining),
  // a drain alone empties, otherwise the held entry stays put.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      data_a_o    <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (capture) begin
      out_valid_o <= 1'b1;
      data_a_o    <= sel_value;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Saturating count of back-to-back hazard cycles, cleared by flush or any gap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (flush_i || !hazard_o) begin
      stall_cnt_o <= '0;
    end else if (stall_cnt_o != CNT_MAX) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_asel_fwd_stage.sv
// Scoreboard bench for asel_fwd_stage: expected operands are queued when a
// capture is predicted and compared while the DUT holds/drains them.
module tb_asel_fwd_stage;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 3;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 4;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                asel;
  logic [REG_AW-1:0]         rs_addr;
  logic [XLEN-1:0]           reg_data;
  logic [XLEN-1:0]           pc;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD-1:0]        fwd_pending;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           data_a;
  logic                      hazard;
  logic [CNT_W-1:0]          stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] sb[$];
  logic            m_valid;
  logic [CNT_W-1:0] m_cnt;

  asel_fwd_stage #(
    .XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .flush_i(flush),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .asel_i(asel),
    .rs_addr_i(rs_addr),
    .reg_data_i(reg_data),
    .pc_i(pc),
    .fwd_valid_i(fwd_valid),
    .fwd_pending_i(fwd_pending),
    .fwd_rd_i(fwd_rd),
    .fwd_data_i(fwd_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .data_a_o(data_a),
    .hazard_o(hazard),
    .stall_cnt_o(stall_cnt)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic setChan(input int k, input logic v, input logic p,
                         input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    fwd_valid[k]                 = v;
    fwd_pending[k]               = p;
    fwd_rd[k*REG_AW +: REG_AW]   = rd;
    fwd_data[k*XLEN +: XLEN]     = d;
  endtask

  task automatic clearChans();
    fwd_valid   = '0;
    fwd_pending = '0;
    fwd_rd      = '0;
    fwd_data    = '0;
  endtask

  // One cycle with the currently driven inputs; called just after a negedge.
  // exp_val is the operand expected to be captured, exp_haz the stall flag.
  task automatic applyStimulus(input logic [XLEN-1:0] exp_val, input logic exp_haz);
    logic exp_rdy;
    logic cap;
    #1;
    checkOutput("hazard", 32'(hazard), 32'(exp_haz));
    exp_rdy = (!m_valid || out_ready) && !exp_haz && !flush;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (m_valid && sb.size() > 0) checkOutput("data_a", data_a, sb[0]);
    cap = in_valid && exp_rdy;
    @(posedge clk);
    if (flush) begin
      sb.delete();
      m_cnt = '0;
    end else begin
      if (m_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (cap) sb.push_back(exp_val);
      if (exp_haz) m_cnt = (m_cnt == {CNT_W{1'b1}}) ? m_cnt : m_cnt + 1'b1;
      else         m_cnt = '0;
    end
    m_valid = (sb.size() > 0);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    applyStimulus('0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; asel = 2'd0; rs_addr = '0;
    reg_data = '0; pc = '0; out_ready = 1'b1;
    clearChans();
    m_valid = 1'b0; m_cnt = '0;

    // Reset values.
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data_a", data_a, 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode select.
    in_valid = 1'b1;
    asel = 2'd1; pc = 32'h0000_1000; applyStimulus(32'h0000_1000, 1'b0);
    asel = 2'd3; pc = 32'hFFFF_FFFC; applyStimulus(32'h0000_0000, 1'b0);
    asel = 2'd2; pc = 32'h1234_5678; applyStimulus(32'h0000_0000, 1'b0);
    asel = 2'd3; pc = 32'h0000_2000; applyStimulus(32'h0000_2004, 1'b0);
    idle();

    // Priority forwarding; the pending ch2 loses to ch0 and raises no stall.
    asel = 2'd0; rs_addr = 5'd5; reg_data = 32'h1111; in_valid = 1'b1;
    setChan(0, 1'b1, 1'b0, 5'd5, 32'hAAAA);
    setChan(1, 1'b1, 1'b0, 5'd6, 32'hCCCC);
    setChan(2, 1'b1, 1'b1, 5'd5, 32'hBBBB);
    applyStimulus(32'hAAAA, 1'b0);
    setChan(0, 1'b0, 1'b0, 5'd5, 32'hAAAA);
    setChan(2, 1'b1, 1'b0, 5'd5, 32'hBBBB);
    applyStimulus(32'hBBBB, 1'b0);
    setChan(2, 1'b0, 1'b0, 5'd5, 32'hBBBB);
    applyStimulus(32'h1111, 1'b0);
    setChan(1, 1'b1, 1'b0, 5'd5, 32'hCCCC);
    applyStimulus(32'hCCCC, 1'b0);
    // Non-REG mode ignores a pending match.
    setChan(1, 1'b1, 1'b1, 5'd5, 32'hCCCC);
    asel = 2'd1; pc = 32'h0000_0400;
    applyStimulus(32'h0000_0400, 1'b0);
    idle();
    clearChans();

    // x0 guard.
    asel = 2'd0; rs_addr = 5'd0; reg_data = 32'h0; in_valid = 1'b1;
    setChan(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
    applyStimulus(32'h0, 1'b0);
    idle();
    clearChans();

    // Load-use for 3 cycles, then the load completes with 0x42.
    rs_addr = 5'd7; in_valid = 1'b1; reg_data = 32'h9999;
    setChan(0, 1'b1, 1'b1, 5'd7, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1);
    setChan(0, 1'b1, 1'b0, 5'd7, 32'h42);
    applyStimulus(32'h42, 1'b0);
    idle();

    // 20-cycle stall saturates the counter.
    in_valid = 1'b1;
    setChan(0, 1'b1, 1'b1, 5'd7, 32'h0);
    for (int i = 0; i < 20; i++) applyStimulus('0, 1'b1);
    checkOutput("stall_sat", 32'(stall_cnt), 32'd15);
    idle();
    clearChans();

    // Backpressure: hold 0x10, then drain and capture on the same edge.
    asel = 2'd1; pc = 32'h10; in_valid = 1'b1; out_ready = 1'b1;
    applyStimulus(32'h10, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h20 + 32'(i);
      applyStimulus(32'h20, 1'b0);
    end
    out_ready = 1'b1; pc = 32'h30;
    applyStimulus(32'h30, 1'b0);
    in_valid = 1'b0;
    checkOutput("full_tput_valid", 32'(out_valid), 32'd1);
    checkOutput("full_tput_data", data_a, 32'h30);
    idle();

    // Flush a held entry while a request is offered.
    in_valid = 1'b1; pc = 32'h55; applyStimulus(32'h55, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; pc = 32'h66; flush = 1'b1;
    applyStimulus(32'h66, 1'b0);
    flush = 1'b0;
    idle();
    checkOutput("post_flush_valid", 32'(out_valid), 32'd0);

    // Flush during a stall clears the counter.
    out_ready = 1'b1; asel = 2'd0; rs_addr = 5'd9; in_valid = 1'b1;
    setChan(1, 1'b1, 1'b1, 5'd9, 32'h0);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    flush = 1'b1;
    applyStimulus('0, 1'b1);
    flush = 1'b0;
    idle();
    clearChans();

    // Asynchronous reset mid-stall with a nonzero held entry.
    asel = 2'd1; pc = 32'h77; in_valid = 1'b1; out_ready = 1'b1;
    applyStimulus(32'h77, 1'b0);
    out_ready = 1'b0; asel = 2'd0; rs_addr = 5'd3;
    setChan(2, 1'b1, 1'b1, 5'd3, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus('0, 1'b1);
    checkOutput("pre_rst_cnt", 32'(stall_cnt), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_data", data_a, 32'd0);
    checkOutput("async_rst_cnt", 32'(stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
